// File: rtl/lockout_controller.sv
// Brute-force lockout gate between the key filter and the lock FSM.
// Repeated wrong entries block keys for a countdown that doubles per consecutive lockout.
module lockout_controller #(
    parameter int MAX_ATTEMPTS  = 3,
    parameter int TICK_CYCLES   = 50000000,
    parameter int LOCKOUT_TICKS = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       fail_pulse,
    input  logic       success_pulse,
    output logic [3:0] key_out,
    output logic       lockout_active,
    output logic [3:0] attempts_left,
    output logic [7:0] countdown,
    output logic       lockout_done
);

    // A one-cycle tick period still needs a 1-bit counter to exist.
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [3:0]    MAX_A     = 4'(MAX_ATTEMPTS);
    localparam logic [7:0]    BASE      = 8'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic {
        ARMED,
        LOCKOUT
    } state_t;

    state_t        r_state;
    logic [3:0]    r_failCount;
    logic [1:0]    r_level;
    logic [TW-1:0] r_tickCnt;
    logic [3:0]    r_keyOut;
    logic          r_lockoutActive;
    logic [3:0]    r_attemptsLeft;
    logic [7:0]    r_countdown;
    logic          r_lockoutDone;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ARMED;
            r_failCount     <= '0;
            r_level         <= '0;
            r_tickCnt       <= '0;
            r_keyOut        <= '0;
            r_lockoutActive <= 1'b0;
            r_attemptsLeft  <= MAX_A;
            r_countdown     <= '0;
            r_lockoutDone   <= 1'b0;
        end else begin
            r_lockoutDone <= 1'b0;
            case (r_state)
                ARMED: begin
                    r_keyOut <= key_in;
                    // Success has priority so a simultaneous fail can never lock the user out.
                    if (success_pulse) begin
                        r_failCount    <= '0;
                        r_level        <= '0;
                        r_attemptsLeft <= MAX_A;
                    end else if (fail_pulse) begin
                        if (r_failCount == MAX_A - 4'd1) begin
                            r_state         <= LOCKOUT;
                            r_failCount     <= '0;
                            r_countdown     <= BASE << r_level;
                            r_tickCnt       <= '0;
                            r_keyOut        <= '0;
                            r_lockoutActive <= 1'b1;
                            r_attemptsLeft  <= '0;
                        end else begin
                            r_failCount    <= r_failCount + 4'd1;
                            r_attemptsLeft <= MAX_A - r_failCount - 4'd1;
                        end
                    end
                end

                LOCKOUT: begin
                    r_keyOut <= '0;
                    if (r_tickCnt == TICK_LAST) begin
                        r_tickCnt   <= '0;
                        r_countdown <= r_countdown - 8'd1;
                        if (r_countdown == 8'd1) begin
                            r_state         <= ARMED;
                            r_lockoutActive <= 1'b0;
                            r_lockoutDone   <= 1'b1;
                            r_attemptsLeft  <= MAX_A;
                            if (r_level != 2'd3) begin
                                r_level <= r_level + 2'd1;
                            end
                        end
                    end else begin
                        r_tickCnt <= r_tickCnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ARMED;
                end
            endcase
        end
    end

    assign key_out        = r_keyOut;
    assign lockout_active = r_lockoutActive;
    assign attempts_left  = r_attemptsLeft;
    assign countdown      = r_countdown;
    assign lockout_done   = r_lockoutDone;

endmodule

// File: tb/tb_lockout_controller.sv
// Directed bench for lockout_controller with short ticks (4 cycles) and a 2-tick base lockout.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_lockout_controller;

    logic       clock;
    logic       reset;
    logic [3:0] key_in;
    logic       fail_pulse;
    logic       success_pulse;
    logic [3:0] key_out;
    logic       lockout_active;
    logic [3:0] attempts_left;
    logic [7:0] countdown;
    logic       lockout_done;

    int checks = 0;
    int fails  = 0;

    lockout_controller #(
        .MAX_ATTEMPTS (3),
        .TICK_CYCLES  (4),
        .LOCKOUT_TICKS(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_in        (key_in),
        .fail_pulse    (fail_pulse),
        .success_pulse (success_pulse),
        .key_out       (key_out),
        .lockout_active(lockout_active),
        .attempts_left (attempts_left),
        .countdown     (countdown),
        .lockout_done  (lockout_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic triggerLockout();
        for (int i = 0; i < 3; i++) begin
            fail_pulse = 1'b1;
            @(negedge clock);
            fail_pulse = 1'b0;
        end
    endtask

    // Observes a lockout already in progress; the bound keeps a stuck DUT from hanging the run.
    task automatic measureLockout(output int len, output logic [7:0] startCd,
                                  output logic [7:0] lastCd, output int dones);
        len     = 0;
        dones   = 0;
        startCd = countdown;
        lastCd  = countdown;
        while (lockout_active === 1'b1 && len < 1000) begin
            lastCd = countdown;
            if (lockout_done === 1'b1) dones++;
            len++;
            @(negedge clock);
        end
        if (lockout_done === 1'b1) dones++;
        @(negedge clock);
        if (lockout_done === 1'b1) dones++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (key_out !== 4'd0) begin fails++; $display("[TB] FAIL reset_key_out: got %0h expected 0", key_out); end
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL reset_active: got %0b expected 0", lockout_active); end
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL reset_attempts: got %0d expected 3", attempts_left); end
        checks++; if (countdown !== 8'd0) begin fails++; $display("[TB] FAIL reset_countdown: got %0d expected 0", countdown); end
        checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0b expected 0", lockout_done); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_passthrough();
        key_in = 4'b0010;
        @(negedge clock);
        key_in = 4'b0000;
        checks++; if (key_out !== 4'b0010) begin fails++; $display("[TB] FAIL pass_one: got %0h expected 2", key_out); end
        @(negedge clock);
        checks++; if (key_out !== 4'b0000) begin fails++; $display("[TB] FAIL pass_one_clear: got %0h expected 0", key_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [3] = '{4'h1, 4'h9, 4'hC};
        for (int i = 0; i < 3; i++) begin
            key_in = seq[i];
            @(negedge clock);
            checks++; if (key_out !== seq[i]) begin fails++; $display("[TB] FAIL b2b_key%0d: got %0h expected %0h", i, key_out, seq[i]); end
        end
        key_in = 4'h0;
        @(negedge clock);
        checks++; if (key_out !== 4'h0) begin fails++; $display("[TB] FAIL b2b_clear: got %0h expected 0", key_out); end
    endtask

    task automatic test_lockout();
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL lock_att3: got %0d expected 3", attempts_left); end
        fail_pulse = 1'b1;
        @(negedge clock);
        fail_pulse = 1'b0;
        checks++; if (attempts_left !== 4'd2) begin fails++; $display("[TB] FAIL lock_att2: got %0d expected 2", attempts_left); end
        fail_pulse = 1'b1;
        @(negedge clock);
        fail_pulse = 1'b0;
        checks++; if (attempts_left !== 4'd1) begin fails++; $display("[TB] FAIL lock_att1: got %0d expected 1", attempts_left); end
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL lock_early: got %0b expected 0", lockout_active); end
        fail_pulse = 1'b1;
        key_in     = 4'h5;
        @(negedge clock);
        fail_pulse = 1'b0;
        key_in     = 4'h0;
        checks++; if (key_out !== 4'h0) begin fails++; $display("[TB] FAIL lock_entry_key_dropped: got %0h expected 0", key_out); end
        checks++; if (attempts_left !== 4'd0) begin fails++; $display("[TB] FAIL lock_att0: got %0d expected 0", attempts_left); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (lockout_active !== 1'b1) begin fails++; $display("[TB] FAIL lock_active_c%0d: got %0b expected 1", k, lockout_active); end
            checks++; if (countdown !== ((k < 4) ? 8'd2 : 8'd1)) begin fails++; $display("[TB] FAIL lock_countdown_c%0d: got %0d expected %0d", k, countdown, (k < 4) ? 2 : 1); end
            checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL lock_done_early_c%0d: got %0b expected 0", k, lockout_done); end
            if (k == 3) begin
                checks++; if (key_out !== 4'h0) begin fails++; $display("[TB] FAIL lock_key_blocked: got %0h expected 0", key_out); end
                key_in        = 4'h0;
                success_pulse = 1'b0;
                fail_pulse    = 1'b0;
            end
            if (k == 2) begin
                key_in        = 4'hF;
                success_pulse = 1'b1;
                fail_pulse    = 1'b1;
            end
            @(negedge clock);
        end
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL lock_exit_active: got %0b expected 0", lockout_active); end
        checks++; if (lockout_done !== 1'b1) begin fails++; $display("[TB] FAIL lock_exit_done: got %0b expected 1", lockout_done); end
        checks++; if (countdown !== 8'd0) begin fails++; $display("[TB] FAIL lock_exit_countdown: got %0d expected 0", countdown); end
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL lock_exit_attempts: got %0d expected 3", attempts_left); end
        @(negedge clock);
        checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL lock_done_width: got %0b expected 0", lockout_done); end
    endtask

    task automatic test_escalation();
        int         expLen [4] = '{16, 32, 64, 64};
        logic [7:0] expCd  [4] = '{8'd4, 8'd8, 8'd16, 8'd16};
        int         len;
        int         dones;
        logic [7:0] startCd;
        logic [7:0] lastCd;
        for (int n = 0; n < 4; n++) begin
            triggerLockout();
            measureLockout(len, startCd, lastCd, dones);
            checks++; if (len !== expLen[n]) begin fails++; $display("[TB] FAIL esc%0d_length: got %0d expected %0d", n + 2, len, expLen[n]); end
            checks++; if (startCd !== expCd[n]) begin fails++; $display("[TB] FAIL esc%0d_start: got %0d expected %0d", n + 2, startCd, expCd[n]); end
            checks++; if (lastCd !== 8'd1) begin fails++; $display("[TB] FAIL esc%0d_last: got %0d expected 1", n + 2, lastCd); end
            checks++; if (dones !== 1) begin fails++; $display("[TB] FAIL esc%0d_done_count: got %0d expected 1", n + 2, dones); end
        end
    endtask

    task automatic test_simultaneous();
        int         len;
        int         dones;
        logic [7:0] startCd;
        logic [7:0] lastCd;
        success_pulse = 1'b1;
        @(negedge clock);
        success_pulse = 1'b0;
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL sim_success_clear: got %0d expected 3", attempts_left); end
        for (int i = 0; i < 2; i++) begin
            fail_pulse = 1'b1;
            @(negedge clock);
            fail_pulse = 1'b0;
        end
        checks++; if (attempts_left !== 4'd1) begin fails++; $display("[TB] FAIL sim_att1: got %0d expected 1", attempts_left); end
        fail_pulse    = 1'b1;
        success_pulse = 1'b1;
        @(negedge clock);
        fail_pulse    = 1'b0;
        success_pulse = 1'b0;
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL sim_no_lockout: got %0b expected 0", lockout_active); end
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL sim_attempts: got %0d expected 3", attempts_left); end
        for (int i = 0; i < 2; i++) begin
            fail_pulse = 1'b1;
            @(negedge clock);
            fail_pulse = 1'b0;
        end
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL sim_count_cleared: got %0b expected 0", lockout_active); end
        fail_pulse = 1'b1;
        @(negedge clock);
        fail_pulse = 1'b0;
        measureLockout(len, startCd, lastCd, dones);
        checks++; if (len !== 8) begin fails++; $display("[TB] FAIL sim_level_cleared_len: got %0d expected 8", len); end
        checks++; if (startCd !== 8'd2) begin fails++; $display("[TB] FAIL sim_level_cleared_start: got %0d expected 2", startCd); end
    endtask

    task automatic test_reset_mid_lockout();
        int         len;
        int         dones;
        logic [7:0] startCd;
        logic [7:0] lastCd;
        triggerLockout();
        checks++; if (countdown !== 8'd4) begin fails++; $display("[TB] FAIL rml_start: got %0d expected 4", countdown); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (lockout_active !== 1'b0) begin fails++; $display("[TB] FAIL rml_active: got %0b expected 0", lockout_active); end
        checks++; if (attempts_left !== 4'd3) begin fails++; $display("[TB] FAIL rml_attempts: got %0d expected 3", attempts_left); end
        checks++; if (countdown !== 8'd0) begin fails++; $display("[TB] FAIL rml_countdown: got %0d expected 0", countdown); end
        checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL rml_done: got %0b expected 0", lockout_done); end
        @(negedge clock);
        checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL rml_done_held: got %0b expected 0", lockout_done); end
        reset  = 1'b1;
        key_in = 4'b0110;
        @(negedge clock);
        key_in = 4'b0000;
        checks++; if (key_out !== 4'b0110) begin fails++; $display("[TB] FAIL rml_first_key: got %0h expected 6", key_out); end
        @(negedge clock);
        checks++; if (lockout_done !== 1'b0) begin fails++; $display("[TB] FAIL rml_no_done_after: got %0b expected 0", lockout_done); end
        triggerLockout();
        measureLockout(len, startCd, lastCd, dones);
        checks++; if (len !== 8) begin fails++; $display("[TB] FAIL rml_level_reset_len: got %0d expected 8", len); end
    endtask

    initial begin
        reset         = 1'b0;
        key_in        = 4'h0;
        fail_pulse    = 1'b0;
        success_pulse = 1'b0;
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_lockout();
        test_escalation();
        test_simultaneous();
        test_reset_mid_lockout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lockout_controller.md
LOCKOUT_CONTROLLER -- requirements
Module: lockout_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MAX_ATTEMPTS, 3: consecutive failed entries that trigger lockout (range 1..15).
- TICK_CYCLES, 50000000: clock cycles per countdown tick (1 s at 50 MHz).
- LOCKOUT_TICKS, 30: base lockout duration in ticks (range 1..31).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- key_in, input, 4: single-cycle key pulses from the key press filter.
- fail_pulse, input, 1: one-cycle pulse from the lock FSM on a wrong password.
- success_pulse, input, 1: one-cycle pulse from the lock FSM on a correct password.
- key_out, output, 4: gated key pulses to the lock FSM.
- lockout_active, output, 1: high while keys are blocked (LED drive).
- attempts_left, output, 4: remaining attempts before lockout.
- countdown, output, 8: remaining lockout ticks, binary.
- lockout_done, output, 1: one-cycle pulse when a lockout ends.

Function
REQ-003 The FSM SHALL have two states: ARMED and LOCKOUT.
REQ-004 ARMED: key_out SHALL equal key_in registered, a latency of 1 cycle.
REQ-005 ARMED, success_pulse=1: fail_count SHALL clear to 0 and level SHALL clear to 0.
REQ-006 ARMED, fail_pulse=1, success_pulse=0, fail_count<MAX_ATTEMPTS-1: fail_count SHALL increment.
REQ-007 ARMED, fail_pulse=1, success_pulse=0, fail_count=MAX_ATTEMPTS-1: on the next edge the block SHALL
- enter LOCKOUT;
- clear fail_count;
- load countdown with LOCKOUT_TICKS<<level;
- clear the tick counter.
REQ-008 If fail_pulse and success_pulse arrive together, success_pulse SHALL win and fail_pulse SHALL be ignored.
REQ-009 A key_in pulse in the same cycle that triggers REQ-007 SHALL be dropped, so key_out=0 on the next cycle.
REQ-010 LOCKOUT: key_out SHALL be 0, and fail_pulse, success_pulse and key_in SHALL be ignored.
REQ-011 LOCKOUT tick counter: it SHALL count 0..TICK_CYCLES-1 and wrap to 0. Each wrap is a tick, and each tick SHALL decrement countdown.
REQ-012 A tick that takes countdown from 1 to 0 SHALL, on the same edge:
- return the FSM to ARMED;
- assert lockout_done for exactly 1 cycle;
- increment level, saturating at 3.
REQ-013 lockout_active SHALL be high for exactly (LOCKOUT_TICKS<<level)*TICK_CYCLES cycles per lockout, where level is the value at lockout entry.
REQ-014 level SHALL be 2 bits, so lockout duration doubles per consecutive lockout up to 8x base. Only success_pulse or reset SHALL clear it.
REQ-015 attempts_left SHALL equal MAX_ATTEMPTS-fail_count in ARMED and 0 in LOCKOUT.
REQ-016 countdown SHALL be 0 in ARMED.
REQ-017 Every output SHALL be driven from a register; there are no combinational input-to-output paths.
REQ-018 The tick counter width SHALL be $clog2(TICK_CYCLES), and all countdown arithmetic SHALL be 8-bit with no overflow for legal parameters.

Reset
REQ-019 While reset=0, the block SHALL hold: state=ARMED, fail_count=0, level=0, tick counter=0, key_out=0, lockout_active=0, attempts_left=MAX_ATTEMPTS, countdown=0, lockout_done=0.
REQ-020 Reset asserted mid-LOCKOUT SHALL abort the lockout immediately, without a lockout_done pulse.
REQ-021 After reset deassertion, the first key_in pulse SHALL appear on key_out one cycle later.

Verification
Bench parameters: MAX_ATTEMPTS=3, TICK_CYCLES=4, LOCKOUT_TICKS=2.
REQ-022 Pass-through: key_in=4'b0010 for 1 cycle in ARMED -> key_out=4'b0010 for exactly 1 cycle, 1 cycle later.
REQ-023 Lockout entry and exit:
- Stimulus: 3 fail_pulses.
- attempts_left steps 3,2,1, then 0 in LOCKOUT.
- lockout_active high for 8 cycles; countdown reads 2,1.
- lockout_done pulses once; attempts_left returns to 3.
REQ-024 Escalation:
- Second lockout without success: lockout_active high 16 cycles, countdown starts at 4.
- Fourth and later lockouts: 64 cycles each (saturated).
REQ-025 Simultaneous events:
- fail_pulse+success_pulse together at fail_count=2 -> no lockout, fail_count=0, level=0.
- key_in during LOCKOUT -> key_out stays 0.
REQ-026 Reset mid-lockout: reset=0 at cycle 3 of LOCKOUT -> all outputs at reset values, no lockout_done, next key_in is passed through.
